// File: rtl/skew_feeder.sv
// Systolic-array input skew stage: row FIFO feeding a per-lane diagonal delay network.
// Optional `SKEW_ROWCNT_EN adds a 16-bit wrapping popped-row counter output row_cnt.
// Samples are carried as 64-bit IEEE-754 bit patterns.

module skew_lane #(
  parameter int STAGES = 0,
  parameter int W      = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         vout,
  output logic         inflight
);
  // Index 0..STAGES-1 are delay stages, STAGES is the output register.
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][W-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (en) begin
      vld_pipe[0] <= load;
      dat_pipe[0] <= load ? din : '0;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign dout = dat_pipe[STAGES];
  assign vout = vld_pipe[STAGES];

  generate
    if (STAGES > 0) begin : g_dly
      assign inflight = |vld_pipe[STAGES-1:0];
    end else begin : g_nodly
      assign inflight = 1'b0;
    end
  endgenerate
endmodule

module skew_feeder #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0][63:0]  x_in,
  input  logic                en,
  output logic [N-1:0][63:0]  x_out,
  output logic [N-1:0]        v_out,
  output logic                busy
`ifdef SKEW_ROWCNT_EN
  ,
  output logic [15:0]         row_cnt
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  logic [N-1:0][63:0] mem [DEPTH];
  logic [N-1:0][63:0] head;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop;
  logic [N-1:0]       lane_inflight;
  state_t             state_q, state_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready ignores a same-cycle pop, so a full FIFO never accepts.
  assign in_ready = !rst && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = en && (count != '0);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= x_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      skew_lane #(.STAGES(i), .W(64)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (pop),
        .din      (head[i]),
        .dout     (x_out[i]),
        .vout     (v_out[i]),
        .inflight (lane_inflight[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Leaving DRAIN once no valid remains ahead of any output register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = RUN;
      RUN:     if (pop && !push && count == CW'(1)) state_d = DRAIN;
      DRAIN: begin
        if (push)                       state_d = RUN;
        else if (en && !(|lane_inflight)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

`ifdef SKEW_ROWCNT_EN
  always_ff @(posedge clk) begin
    if (rst)      row_cnt <= '0;
    else if (pop) row_cnt <= row_cnt + 16'd1;
  end
`endif
endmodule
